// File: rtl/pulse_stretch_if.sv
// Event/level bundle for pulse_stretch: the event input plus the stretched level,
// busy flag, pending-event count and overflow strobe.
interface pulse_stretch_if #(
   parameter int unsigned PEND_W = 3
);
   logic              in;
   logic              out;
   logic              busy;
   logic [PEND_W-1:0] pend;
   logic              ovf;

   modport master (
      output in,
      input  out,
      input  busy,
      input  pend,
      input  ovf
   );

   modport slave (
      input  in,
      output out,
      output busy,
      output pend,
      output ovf
   );
endinterface

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into HIGH_CYC-long output windows separated by
// GAP_CYC low cycles; events seen while busy are queued in a saturating counter.
module pulse_stretch #(
   parameter int unsigned HIGH_CYC = 10_000_000,
   parameter int unsigned GAP_CYC  = 5_000_000,
   parameter int unsigned PEND_W   = 3,
   parameter int unsigned RETRIG   = 0
) (
   input logic             clk,
   input logic             rst_n,
   pulse_stretch_if.slave  bus
);

   localparam int unsigned CNT_MAX = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]  HIGH_LD  = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYC - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_GAP
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [PEND_W-1:0] pend_q,  pend_d;
   logic              out_q,   out_d;
   logic              busy_q,  busy_d;
   logic              ovf_q,   ovf_d;
   logic              inc;
   logic              dec;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inc     = 1'b0;
      dec     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in) begin
               state_d = S_HIGH;
               cnt_d   = HIGH_LD;
            end
         end

         S_HIGH: begin
            // A retrigger reload takes priority over expiry, so the window never drops.
            if (bus.in && (RETRIG != 0)) begin
               cnt_d = HIGH_LD;
            end else begin
               inc = bus.in;
               if (cnt_q == '0) begin
                  state_d = S_GAP;
                  cnt_d   = GAP_LD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               inc   = bus.in;
            end else if (pend_q != '0) begin
               state_d = S_HIGH;
               cnt_d   = HIGH_LD;
               dec     = 1'b1;
               inc     = bus.in;
            end else if (bus.in) begin
               // Event on the last gap cycle with an empty queue starts the next window directly.
               state_d = S_HIGH;
               cnt_d   = HIGH_LD;
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      ovf_d  = 1'b0;
      if (inc && !dec) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end else if (dec && !inc) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_comb begin
      out_d  = (state_d == S_HIGH);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.busy = busy_q;
   assign bus.pend = pend_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Drives a queueing and a retriggering pulse_stretch side by side and compares every
// output each cycle against an interval-based reference model.
module tb_pulse_stretch;

   localparam int H  = 4;
   localparam int G  = 2;
   localparam int PW = 2;
   localparam int PMAX = (1 << PW) - 1;

   logic clk = 1'b0;
   logic rst_n;

   pulse_stretch_if #(.PEND_W(PW)) if0 ();
   pulse_stretch_if #(.PEND_W(PW)) if1 ();

   pulse_stretch #(
      .HIGH_CYC (H),
      .GAP_CYC  (G),
      .PEND_W   (PW),
      .RETRIG   (0)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   pulse_stretch #(
      .HIGH_CYC (H),
      .GAP_CYC  (G),
      .PEND_W   (PW),
      .RETRIG   (1)
   ) u_retrig (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   always #5 clk = ~clk;

   // Model: the current window is high over cycles up to hi_end and low-but-busy up to gap_end.
   typedef struct {
      int hi_end;
      int gap_end;
      int pend;
      int ovf;
   } model_t;

   model_t m0, m1;
   int     cyc    = 0;
   int     checks = 0;
   int     errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic model_t mstep(input model_t s, input int n, input bit rst,
                                    input bit ev, input bit retrig);
      model_t r;
      bit     inc;
      bit     dec;
      r   = s;
      inc = 1'b0;
      dec = 1'b0;
      r.ovf = 0;
      if (!rst) begin
         r.hi_end  = -1;
         r.gap_end = -1;
         r.pend    = 0;
         return r;
      end
      if (n > s.gap_end) begin
         if (ev) begin
            r.hi_end  = n + H;
            r.gap_end = n + H + G;
         end
      end else if (n <= s.hi_end) begin
         if (ev && retrig) begin
            r.hi_end  = n + H;
            r.gap_end = n + H + G;
         end else begin
            inc = ev;
         end
      end else if (n < s.gap_end) begin
         inc = ev;
      end else begin
         if (s.pend > 0) begin
            r.hi_end  = n + H;
            r.gap_end = n + H + G;
            dec = 1'b1;
            inc = ev;
         end else if (ev) begin
            r.hi_end  = n + H;
            r.gap_end = n + H + G;
         end
      end
      if (inc && !dec) begin
         if (s.pend == PMAX) r.ovf = 1;
         else                r.pend = s.pend + 1;
      end else if (dec && !inc) begin
         r.pend = s.pend - 1;
      end
      return r;
   endfunction

   task automatic step(input bit r, input bit e0, input bit e1);
      rst_n  = r;
      if0.in = e0;
      if1.in = e1;
      @(posedge clk);
      m0 = mstep(m0, cyc, r, e0, 1'b0);
      m1 = mstep(m1, cyc, r, e1, 1'b1);
      #1;
      check("q_out",  int'(if0.out),  int'((cyc + 1) <= m0.hi_end));
      check("q_busy", int'(if0.busy), int'((cyc + 1) <= m0.gap_end));
      check("q_pend", int'(if0.pend), m0.pend);
      check("q_ovf",  int'(if0.ovf),  m0.ovf);
      check("r_out",  int'(if1.out),  int'((cyc + 1) <= m1.hi_end));
      check("r_busy", int'(if1.busy), int'((cyc + 1) <= m1.gap_end));
      check("r_pend", int'(if1.pend), m1.pend);
      check("r_ovf",  int'(if1.ovf),  m1.ovf);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic burst(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      int unsigned dens;
      bit          e0, e1, r;
      m0 = '{hi_end: -1, gap_end: -1, pend: 0, ovf: 0};
      m1 = m0;

      // Reset held with the event input high, then release.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
      idle(3);

      // Single event.
      burst(1);
      idle(10);

      // Two events two cycles apart.
      burst(1); idle(1); burst(1);
      idle(16);

      // Five consecutive events saturate the queue.
      burst(5);
      idle(30);

      // Events three cycles apart.
      burst(1); idle(2); burst(1);
      idle(16);

      // Retrigger exactly on the last high cycle.
      burst(1); idle(3); burst(1);
      idle(16);

      // Event on the last gap cycle with an empty queue.
      burst(1); idle(5); burst(1);
      idle(16);

      // Reset in the middle of a window with a queued backlog.
      burst(3);
      step(1'b0, 1'b0, 1'b0);
      burst(1);
      idle(12);

      // Randomized traffic with varying event density and rare resets.
      for (int seg = 0; seg < 30; seg++) begin
         dens = $urandom_range(1, 9);
         for (int i = 0; i < 100; i++) begin
            e0 = ($urandom_range(0, 9) < dens);
            e1 = ($urandom_range(0, 9) < dens);
            r  = ($urandom_range(0, 249) != 0);
            step(r, e0, e1);
         end
      end
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
